// File: rtl/downcounter_pkg.sv
// Shared definitions for the downcounter block.
//   DefaultWidth : default counter width in bits.
//   count_t      : counter value type at the default width.
//   next_count() : pure next-state function (decrement or reload).
package downcounter_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef logic [DefaultWidth-1:0] count_t;

  // Values are carried at the widest legal counter width (32 bits); callers
  // truncate the result back to their own width.
  // Decrements only while above the terminal value, so the subtraction can
  // never borrow. Any value at or below terminal reloads.
  function automatic logic [31:0] next_count(input logic [31:0] cur,
                                             input logic [31:0] load_val,
                                             input logic [31:0] term_val);
    if (cur > term_val) begin
      return cur - 32'd1;
    end
    return load_val;
  endfunction

endpackage

// File: rtl/downcounter.sv
// Free-running synchronous binary down-counter with a programmable reload window.
// Counts LOAD_VALUE, LOAD_VALUE-1, ..., TERMINAL_VALUE, then reloads LOAD_VALUE.
// Ports (positional order is fixed for legacy instantiations):
//   clock : rising-edge clock
//   count : current counter value, driven straight from the state register
//   reset : asynchronous active-low reset; forces count to LOAD_VALUE
module downcounter
  import downcounter_pkg::*;
#(
  parameter int unsigned     WIDTH          = DefaultWidth,
  parameter longint unsigned LOAD_VALUE     = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned TERMINAL_VALUE = 64'd0
) (
  input  logic             clock,
  output logic [WIDTH-1:0] count,
  input  logic             reset
);

  // Reject illegal parameter sets while elaborating.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "downcounter: WIDTH must be in 1..32");
  end
  if (LOAD_VALUE >= (64'd1 << WIDTH)) begin : g_bad_load
    $fatal(1, "downcounter: LOAD_VALUE does not fit in WIDTH bits");
  end
  if (TERMINAL_VALUE > LOAD_VALUE) begin : g_bad_window
    $fatal(1, "downcounter: TERMINAL_VALUE exceeds LOAD_VALUE");
  end

  localparam logic [WIDTH-1:0] LoadVal = WIDTH'(LOAD_VALUE);
  localparam logic [WIDTH-1:0] TermVal = WIDTH'(TERMINAL_VALUE);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = WIDTH'(next_count(32'(count_q), 32'(LoadVal), 32'(TermVal)));
  end

  // Reset acts as an asynchronous preset to LoadVal.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= LoadVal;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_downcounter.sv
module tb_downcounter;

  logic       clock;
  logic       reset;
  logic [3:0] cnt_a;  // defaults: 15..0
  logic [3:0] cnt_b;  // window 10..3
  logic [3:0] cnt_c;  // degenerate 5..5
  logic [7:0] cnt_d;  // width 8: 255..0

  int tests;
  int fails;

  downcounter u_dut_a (
    .clock(clock),
    .count(cnt_a),
    .reset(reset)
  );

  downcounter #(
    .WIDTH(4),
    .LOAD_VALUE(10),
    .TERMINAL_VALUE(3)
  ) u_dut_b (
    .clock(clock),
    .count(cnt_b),
    .reset(reset)
  );

  downcounter #(
    .WIDTH(4),
    .LOAD_VALUE(5),
    .TERMINAL_VALUE(5)
  ) u_dut_c (
    .clock(clock),
    .count(cnt_c),
    .reset(reset)
  );

  downcounter #(
    .WIDTH(8)
  ) u_dut_d (
    .clock(clock),
    .count(cnt_d),
    .reset(reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse reset for two cycles, leaving reset released just after a falling edge.
  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    // Before any clock edge has happened.
    tests++;
    if (cnt_a !== 4'd15) begin
      fails++;
      $display("FAIL reset_pre_edge: got %0d, want 15", cnt_a);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests++;
      if (cnt_a !== 4'd15) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got %0d, want 15", i, cnt_a);
      end
    end
    tests++;
    if (cnt_b !== 4'd10 || cnt_c !== 4'd5 || cnt_d !== 8'd255) begin
      fails++;
      $display("FAIL reset_others: got %0d/%0d/%0d, want 10/5/255", cnt_b, cnt_c, cnt_d);
    end
  endtask

  task automatic test_count();
    logic [3:0] exp;
    reset = 1'b1;
    exp = 4'd15;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      exp = (exp == 4'd0) ? 4'd15 : exp - 4'd1;
      tests++;
      if (cnt_a !== exp) begin
        fails++;
        $display("FAIL count_edge%0d: got %0d, want %0d", k, cnt_a, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    // Six edges after release: 14,13,12,11,10,9.
    repeat (6) @(negedge clock);
    tests++;
    if (cnt_a !== 4'd9) begin
      fails++;
      $display("FAIL async_pre: got %0d, want 9", cnt_a);
    end
    @(posedge clock);
    #2;
    tests++;
    if (cnt_a !== 4'd8) begin
      fails++;
      $display("FAIL async_pre_assert: got %0d, want 8", cnt_a);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (cnt_a !== 4'd15) begin
      fails++;
      $display("FAIL async_immediate: got %0d, want 15", cnt_a);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (cnt_a !== 4'd14) begin
      fails++;
      $display("FAIL async_first_edge: got %0d, want 14", cnt_a);
    end
  endtask

  task automatic test_window();
    logic [3:0] seq [10] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd10, 4'd9, 4'd8};
    pulse_reset();
    tests++;
    if (cnt_b !== 4'd10) begin
      fails++;
      $display("FAIL window_start: got %0d, want 10", cnt_b);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      tests++;
      if (cnt_b !== seq[k]) begin
        fails++;
        $display("FAIL window_edge%0d: got %0d, want %0d", k + 1, cnt_b, seq[k]);
      end
    end
  endtask

  task automatic test_degenerate();
    pulse_reset();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      tests++;
      if (cnt_c !== 4'd5) begin
        fails++;
        $display("FAIL degenerate_edge%0d: got %0d, want 5", k, cnt_c);
      end
    end
  endtask

  task automatic test_wide();
    pulse_reset();
    for (int k = 1; k <= 257; k++) begin
      @(negedge clock);
      if (k == 1 || k == 255 || k == 256 || k == 257) begin
        logic [7:0] exp;
        exp = (k == 1) ? 8'd254 : (k == 255) ? 8'd0 : (k == 256) ? 8'd255 : 8'd254;
        tests++;
        if (cnt_d !== exp) begin
          fails++;
          $display("FAIL wide_edge%0d: got %0d, want %0d", k, cnt_d, exp);
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_count();
    test_async_reset();
    test_window();
    test_degenerate();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
